// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder: direction and phase encodings,
// transition classification and a counter-width helper.
package quad_pkg;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   // Phase pair is {a, b}; UP walks 00 -> 10 -> 11 -> 01 -> 00.
   localparam logic [1:0] PH_00 = 2'b00;
   localparam logic [1:0] PH_10 = 2'b10;
   localparam logic [1:0] PH_11 = 2'b11;
   localparam logic [1:0] PH_01 = 2'b01;

   typedef enum logic [1:0] {
      TR_NONE,
      TR_UP,
      TR_DOWN,
      TR_ILLEGAL
   } trans_t;

   typedef enum logic {
      ST_INIT,
      ST_TRACK
   } mode_t;

   function automatic trans_t decode_trans(input logic [1:0] prev, input logic [1:0] next);
      trans_t t;
      if (prev == next) begin
         t = TR_NONE;
      end else begin
         case ({prev, next})
            {PH_00, PH_10},
            {PH_10, PH_11},
            {PH_11, PH_01},
            {PH_01, PH_00}: t = TR_UP;
            {PH_00, PH_01},
            {PH_01, PH_11},
            {PH_11, PH_10},
            {PH_10, PH_00}: t = TR_DOWN;
            default:        t = TR_ILLEGAL;
         endcase
      end
      return t;
   endfunction

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Per-channel input conditioning: multi-flop synchroniser followed by a
// stability filter that accepts a new level only after it has held steadily.
module quad_input_filter
   import quad_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic level,
   output logic settled
);

   localparam int CW = cnt_width(FILTER_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

   logic [SYNC_STAGES-1:0] chain;
   logic [CW-1:0]          stable_cnt;
   logic                   sync;

   assign sync = chain[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         chain      <= '0;
         stable_cnt <= '0;
         level      <= 1'b0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], pin};
         if (sync == level) begin
            stable_cnt <= '0;
         end else if (stable_cnt == CNT_LAST) begin
            level      <= sync;
            stable_cnt <= '0;
         end else begin
            stable_cnt <= stable_cnt + CW'(1);
         end
      end
   end

   // Nothing in flight anywhere between the pin sampler and the accepted level.
   assign settled = (chain == {SYNC_STAGES{level}}) && (stable_cnt == '0);

endmodule

// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: filters both phases, classifies each accepted phase
// change and maintains a wrap-around position count, direction, step and error.
module quad_decoder
   import quad_pkg::*;
#(
   parameter int WIDTH         = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a,
   input  logic             b,
   input  logic             clr,
   output logic [WIDTH-1:0] count,
   output logic             dir,
   output logic             step,
   output logic             err
);

   localparam int RW = cnt_width(FILTER_CYCLES);
   localparam logic [RW-1:0] REST_LAST = RW'(FILTER_CYCLES - 1);

   logic          a_f, b_f;
   logic          a_settled, b_settled;
   logic [1:0]    pair;
   logic [1:0]    ref_ph;
   trans_t        trans;
   mode_t         mode;
   logic          primed;
   logic [RW-1:0] rest_cnt;
   logic          rest_ok;

   quad_input_filter #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
   ) u_filt_a (
      .clk    (clk),
      .reset  (reset),
      .pin    (a),
      .level  (a_f),
      .settled(a_settled)
   );

   quad_input_filter #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
   ) u_filt_b (
      .clk    (clk),
      .reset  (reset),
      .pin    (b),
      .level  (b_f),
      .settled(b_settled)
   );

   assign pair  = {a_f, b_f};
   assign trans = decode_trans(ref_ph, pair);

   // The first edge after reset has no genuine pin sample in the synchroniser
   // yet, so the rest-at-00 window only opens once primed is set.
   assign rest_ok = primed && a_settled && b_settled && (pair == PH_00);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count    <= '0;
         dir      <= DIR_UP;
         step     <= 1'b0;
         err      <= 1'b0;
         ref_ph   <= PH_00;
         mode     <= ST_INIT;
         primed   <= 1'b0;
         rest_cnt <= '0;
      end else begin
         primed <= 1'b1;
         step   <= 1'b0;
         case (mode)
            ST_INIT: begin
               if (pair != ref_ph) begin
                  ref_ph <= pair;
                  mode   <= ST_TRACK;
               end else if (rest_ok) begin
                  if (rest_cnt == REST_LAST) mode <= ST_TRACK;
                  else                       rest_cnt <= rest_cnt + RW'(1);
               end else begin
                  rest_cnt <= '0;
               end
            end
            ST_TRACK: begin
               case (trans)
                  TR_UP: begin
                     count  <= count + WIDTH'(1);
                     dir    <= DIR_UP;
                     step   <= 1'b1;
                     ref_ph <= pair;
                  end
                  TR_DOWN: begin
                     count  <= count - WIDTH'(1);
                     dir    <= DIR_DOWN;
                     step   <= 1'b1;
                     ref_ph <= pair;
                  end
                  TR_ILLEGAL: begin
                     err    <= 1'b1;
                     ref_ph <= pair;
                  end
                  default: ;
               endcase
            end
            default: mode <= ST_INIT;
         endcase
         // Clear wins over a same-cycle step on count; step and dir still report it.
         if (clr) begin
            count <= '0;
            err   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: a small phase model predicts each step
// event into a scoreboard that is drained as the DUT pulses step.
module tb_quad_decoder;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             a, b, clr;
   logic [WIDTH-1:0] count;
   logic             dir, step, err;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      int               cyc_due;
      logic [WIDTH-1:0] cnt;
      logic             dir;
   } exp_t;

   exp_t sb[$];

   logic [WIDTH-1:0] m_count;
   logic             m_dir, m_err;
   logic [1:0]       m_pins;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   quad_decoder #(
      .WIDTH        (WIDTH),
      .SYNC_STAGES  (2),
      .FILTER_CYCLES(2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .a    (a),
      .b    (b),
      .clr  (clr),
      .count(count),
      .dir  (dir),
      .step (step),
      .err  (err)
   );

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic check_state(input string tag);
      check_val({tag, "_count"}, 32'(count), 32'(m_count));
      check_val({tag, "_dir"},   32'(dir),   32'(m_dir));
      check_val({tag, "_err"},   32'(err),   32'(m_err));
   endtask

   // Position of a phase pair along the UP cycle 00,10,11,01.
   function automatic int ph_idx(input logic [1:0] v);
      case (v)
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (reset === 1'b1 && step === 1'b1) begin
         if (sb.size() == 0) begin
            check_val("spurious_step", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check_val("step_cycle", 32'(cyc), 32'(e.cyc_due));
            check_val("step_count", 32'(count), 32'(e.cnt));
            check_val("step_dir",   32'(dir),   32'(e.dir));
         end
      end
   end

   // Called on a falling edge; the change becomes visible 5 rising edges later.
   task automatic move(input logic na, input logic nb);
      logic [1:0] nv;
      int         d;
      exp_t       e;
      nv = {na, nb};
      d  = (ph_idx(nv) - ph_idx(m_pins) + 4) % 4;
      a  = na;
      b  = nb;
      if (d == 1) begin
         m_count = m_count + 1'b1;
         m_dir   = 1'b0;
      end else if (d == 3) begin
         m_count = m_count - 1'b1;
         m_dir   = 1'b1;
      end else if (d == 2) begin
         m_err = 1'b1;
      end
      if (d == 1 || d == 3) begin
         e.cyc_due = cyc + 5;
         e.cnt     = m_count;
         e.dir     = m_dir;
         sb.push_back(e);
      end
      m_pins = nv;
      repeat (10) @(negedge clk);
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      @(negedge clk);
      clr     = 1'b0;
      m_count = '0;
      m_err   = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      a = 1'b0; b = 1'b0; clr = 1'b0; reset = 1'b0;
      m_count = '0; m_dir = 1'b0; m_err = 1'b0; m_pins = 2'b00;
      repeat (3) @(negedge clk);
      check_val("rst_step", 32'(step), 32'd0);
      check_state("rst");
      reset = 1'b1;
      repeat (10) @(negedge clk);

      // Four UP steps from rest at 00
      move(1'b1, 1'b0);
      move(1'b1, 1'b1);
      move(1'b0, 1'b1);
      move(1'b0, 1'b0);
      check_state("up4");
      pulse_clr();
      check_state("clr0");

      // DOWN wrap, then back up
      move(1'b0, 1'b1);
      check_state("wrap_down");
      move(1'b0, 1'b0);
      move(1'b1, 1'b0);
      check_state("up_after_wrap");
      move(1'b0, 1'b0);

      // One-cycle glitch on a must be rejected
      a = 1'b1;
      @(negedge clk);
      a = 1'b0;
      repeat (10) @(negedge clk);
      check_state("glitch");
      move(1'b1, 1'b0);
      check_state("held_a");
      move(1'b0, 1'b0);

      // Both channels together: illegal, sticky err
      move(1'b1, 1'b1);
      check_state("illegal");
      repeat (5) @(negedge clk);
      check_val("err_sticky", 32'(err), 32'd1);
      pulse_clr();
      check_state("illegal_clr");

      // Pins held at 11 through reset
      #3 reset = 1'b0;
      sb.delete();
      m_count = '0; m_dir = 1'b0; m_err = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (12) @(negedge clk);
      check_state("init11");
      move(1'b0, 1'b1);
      check_state("init11_step");

      // Clear coincident with an accepted DOWN step (01 -> 11)
      a = 1'b1; b = 1'b1;
      e.cyc_due = cyc + 5;
      e.cnt     = '0;
      e.dir     = 1'b1;
      sb.push_back(e);
      repeat (4) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      m_count = '0; m_dir = 1'b1; m_pins = 2'b11;
      repeat (8) @(negedge clk);
      check_state("clr_step");

      move(1'b0, 1'b1);
      move(1'b0, 1'b0);
      move(1'b0, 1'b1);
      check_state("pre_reset");

      // Reset during an in-flight change: outputs drop without a clock edge
      a = 1'b0; b = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      m_count = '0; m_dir = 1'b0; m_err = 1'b0; m_pins = 2'b00;
      sb.delete();
      check_val("async_step", 32'(step), 32'd0);
      check_state("async");
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      check_state("rest00");
      move(1'b1, 1'b0);
      check_state("rest00_step");

      check_val("sb_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
